// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// ----------------------------------------------------------------------------
// Loads a program into the instruction memory from a byte stream. Bytes are
// packed little-endian into 32-bit words. Each completed word is written into
// the memory over the shared data bus during a one-cycle write slot. When the
// requested number of words has been written, the loader releases the memory
// to the CPU (prg_mode = 1).
//
// Parameters
//   MEM_DEPTH       number of 32-bit words in the instruction memory
//   CNT_W           width of word_count and of the internal word index
//
// Ports
//   clk_input       rising-edge clock shared with the instruction memory
//   rst_n           asynchronous active-low reset
//   start           single-cycle pulse that begins a load (ignored while busy)
//   word_count      number of words to load, sampled together with start
//   in_byte         program byte stream data
//   in_valid        in_byte is valid
//   in_ready        loader accepts in_byte this cycle (COLLECT only)
//   address_pointer memory word address; index during WRITE, 0 otherwise
//   BUS             shared memory data bus; driven only during WRITE
//   we              memory write enable (WRITE only)
//   prg_mode        0 = programming / CPU held, 1 = run (DONE)
//   busy            load in progress (COLLECT or WRITE)
//   err             sticky: the last start carried an illegal word_count
// ============================================================================
module imem_loader #(
    parameter int MEM_DEPTH = 151,
    parameter int CNT_W     = 8
) (
    input  logic             clk_input,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      address_pointer,
    inout  wire  [31:0]      BUS,
    output logic             we,
    output logic             prg_mode,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    logic [1:0]       state_q,    state_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [CNT_W-1:0] index_q,    index_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             err_q,      err_d;
    logic [31:0]      wdata_q,    wdata_d;

    logic [31:0]      wc_ext;
    logic             wc_zero;
    logic             wc_over;
    logic [CNT_W-1:0] index_inc;
    logic             byte_xfer;

    // Compare at 32 bits so a MEM_DEPTH that does not fit in CNT_W still
    // classifies counts correctly.
    assign wc_ext    = 32'(word_count);
    assign wc_zero   = (word_count == '0);
    assign wc_over   = (wc_ext > DEPTH_W);
    assign index_inc = index_q + 1'b1;
    assign byte_xfer = in_valid && (state_q == ST_COLLECT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        err_d      = err_q;
        wdata_d    = wdata_q;

        case (state_q)
            // IDLE and DONE accept a new load under identical rules; an
            // illegal count leaves the state alone so a loaded program in
            // DONE keeps running.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (wc_zero) begin
                        state_d = ST_DONE;
                        err_d   = 1'b0;
                    end else if (wc_over) begin
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_COLLECT;
                        count_d    = word_count;
                        index_d    = '0;
                        byte_cnt_d = 2'd0;
                        err_d      = 1'b0;
                    end
                end
            end

            ST_COLLECT: begin
                if (byte_xfer) begin
                    case (byte_cnt_q)
                        2'd0:    wdata_d[7:0]   = in_byte;
                        2'd1:    wdata_d[15:8]  = in_byte;
                        2'd2:    wdata_d[23:16] = in_byte;
                        default: wdata_d[31:24] = in_byte;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                index_d    = index_inc;
                byte_cnt_d = 2'd0;
                // Leaving on index_inc == count keeps the last write at
                // count-1, so a full-depth load never touches MEM_DEPTH.
                if (index_inc == count_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            index_q    <= '0;
            byte_cnt_q <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Word assembly register (no reset: clearing byte_cnt_q on reset
    // already discards any partial word, and every byte lane is rewritten
    // before the next WRITE)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_input) begin
        wdata_q <= wdata_d;
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the state register so reset forces them at once
    // ------------------------------------------------------------------
    assign in_ready        = (state_q == ST_COLLECT);
    assign we              = (state_q == ST_WRITE);
    assign busy            = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    assign prg_mode        = (state_q == ST_DONE);
    assign err             = err_q;
    assign address_pointer = (state_q == ST_WRITE) ? 32'(index_q) : 32'd0;
    assign BUS             = (state_q == ST_WRITE) ? wdata_q : 32'bz;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int MEM_DEPTH = 151;
    localparam int CNT_W     = 8;

    logic             clk_input = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      address_pointer;
    wire  [31:0]      BUS;
    logic             we;
    logic             prg_mode;
    logic             busy;
    logic             err;

    // Memory model on the shared bus, plus a probe driver used to show the
    // loader has released the bus.
    logic [31:0] mem [0:255];
    logic [31:0] pc;
    logic        probe_en;
    logic [31:0] probe_val;
    logic [31:0] mem_addr;
    logic        tb_en;
    logic [31:0] tb_val;

    int checks     = 0;
    int errors     = 0;
    int we_count   = 0;
    int bad_addr   = 0;
    int last_addr  = -1;

    assign mem_addr = prg_mode ? pc : address_pointer;
    assign tb_en    = probe_en || (prg_mode && !we);
    assign tb_val   = probe_en ? probe_val : mem[mem_addr[7:0]];
    assign BUS      = tb_en ? tb_val : 32'bz;

    imem_loader #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
        .clk_input       (clk_input),
        .rst_n           (rst_n),
        .start           (start),
        .word_count      (word_count),
        .in_byte         (in_byte),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .address_pointer (address_pointer),
        .BUS             (BUS),
        .we              (we),
        .prg_mode        (prg_mode),
        .busy            (busy),
        .err             (err)
    );

    always #5 clk_input = ~clk_input;

    // Memory write port: captures on the falling edge, mid WRITE cycle.
    always @(negedge clk_input) begin
        if (we) begin
            we_count  <= we_count + 1;
            last_addr <= int'(address_pointer);
            if (address_pointer >= 32'(MEM_DEPTH)) bad_addr <= bad_addr + 1;
            else mem[address_pointer[7:0]] <= BUS;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_input);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus_released(input string tag);
        probe_val = 32'hA5C3_5A3C;
        probe_en  = 1'b1;
        #1;
        chk(tag, BUS, 32'hA5C3_5A3C);
        probe_en  = 1'b0;
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_byte  = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Sends one word and checks the following WRITE cycle.
    task automatic load_word(input logic [31:0] w, input logic [31:0] addr);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
        chk("write_we",   {31'd0, we}, 32'd1);
        chk("write_addr", address_pointer, addr);
        chk("write_bus",  BUS, w);
        chk("write_rdy",  {31'd0, in_ready}, 32'd0);
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] wc);
        start      = 1'b1;
        word_count = wc;
        step();
        start      = 1'b0;
    endtask

    task automatic read_mem(input string tag, input logic [31:0] a, input logic [31:0] exp);
        pc = a;
        #1;
        chk(tag, BUS, exp);
    endtask

    initial begin
        int we_base;
        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        in_byte    = 8'h00;
        in_valid   = 1'b0;
        pc         = 32'd0;
        probe_en   = 1'b0;
        probe_val  = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;

        // Reset state
        step();
        step();
        chk("rst_prg",   {31'd0, prg_mode}, 32'd0);
        chk("rst_we",    {31'd0, we},       32'd0);
        chk("rst_rdy",   {31'd0, in_ready}, 32'd0);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_err",   {31'd0, err},      32'd0);
        chk("rst_addr",  address_pointer,   32'd0);
        chk_bus_released("rst_bus_z");
        rst_n = 1'b1;
        step();

        // Two-word load
        we_base = we_count;
        pulse_start(8'd2);
        chk("coll_rdy",  {31'd0, in_ready}, 32'd1);
        chk("coll_busy", {31'd0, busy},     32'd1);
        chk("coll_prg",  {31'd0, prg_mode}, 32'd0);
        chk_bus_released("coll_bus_z");
        load_word(32'h1234_5678, 32'd0);
        chk("write_busy", {31'd0, busy},     32'd1);
        chk("write_prg",  {31'd0, prg_mode}, 32'd0);
        load_word(32'hDEAD_BEEF, 32'd1);
        step();
        chk("done_prg",   {31'd0, prg_mode}, 32'd1);
        chk("done_busy",  {31'd0, busy},     32'd0);
        chk("done_we",    {31'd0, we},       32'd0);
        chk("done_addr",  address_pointer,   32'd0);
        chk("two_we_cnt", 32'(we_count - we_base), 32'd2);
        read_mem("rd_w0", 32'd0, 32'h1234_5678);
        read_mem("rd_w1", 32'd1, 32'hDEAD_BEEF);

        // Illegal count from DONE: error raised, program keeps running
        pulse_start(8'd200);
        chk("ill_done_err", {31'd0, err},      32'd1);
        chk("ill_done_prg", {31'd0, prg_mode}, 32'd1);

        // Reload from DONE, stalled stream, starts while busy ignored
        we_base = we_count;
        pulse_start(8'd1);
        chk("reload_prg", {31'd0, prg_mode}, 32'd0);
        chk("reload_err", {31'd0, err},      32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 0; i < 5; i++) begin
            start      = (i == 2);
            word_count = 8'd3;
            step();
            chk("stall_rdy", {31'd0, in_ready}, 32'd1);
            chk("stall_we",  {31'd0, we},       32'd0);
        end
        start = 1'b0;
        send_byte(8'h33);
        send_byte(8'h44);
        chk("stall_we1",  {31'd0, we}, 32'd1);
        chk("stall_addr", address_pointer, 32'd0);
        chk("stall_bus",  BUS, 32'h4433_2211);
        start      = 1'b1;
        word_count = 8'd2;
        step();
        start = 1'b0;
        chk("busy_ign_prg", {31'd0, prg_mode}, 32'd1);
        chk("stall_we_cnt", 32'(we_count - we_base), 32'd1);
        read_mem("rd_stall", 32'd0, 32'h4433_2211);

        // Illegal counts from IDLE
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        we_base = we_count;
        pulse_start(8'd152);
        chk("ill_err",  {31'd0, err},      32'd1);
        chk("ill_busy", {31'd0, busy},     32'd0);
        chk("ill_rdy",  {31'd0, in_ready}, 32'd0);
        chk("ill_prg",  {31'd0, prg_mode}, 32'd0);
        step();
        step();
        chk("ill_no_we", 32'(we_count - we_base), 32'd0);
        pulse_start(8'd0);
        chk("zero_prg",  {31'd0, prg_mode}, 32'd1);
        chk("zero_err",  {31'd0, err},      32'd0);
        chk("zero_busy", {31'd0, busy},     32'd0);
        step();
        chk("zero_no_we", 32'(we_count - we_base), 32'd0);

        // Reset mid-load after 6 bytes of a 3-word load
        pulse_start(8'd3);
        load_word(32'h0403_0201, 32'd0);
        send_byte(8'h05);
        send_byte(8'h06);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy},     32'd0);
        chk("arst_rdy",  {31'd0, in_ready}, 32'd0);
        chk("arst_prg",  {31'd0, prg_mode}, 32'd0);
        chk("arst_we",   {31'd0, we},       32'd0);
        chk("arst_addr", address_pointer,   32'd0);
        chk("arst_err",  {31'd0, err},      32'd0);
        chk_bus_released("arst_bus_z");
        step();
        rst_n = 1'b1;
        step();
        pulse_start(8'd1);
        load_word(32'hDDCC_BBAA, 32'd0);
        step();
        chk("arst_done", {31'd0, prg_mode}, 32'd1);
        read_mem("rd_arst0", 32'd0, 32'hDDCC_BBAA);
        read_mem("rd_arst1", 32'd1, 32'hDEAD_BEEF);

        // Full-depth load
        we_base  = we_count;
        bad_addr = 0;
        pulse_start(8'd151);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            load_word({8'hC0, ib, 8'h5A, ~ib}, 32'(i));
        end
        step();
        chk("full_prg",    {31'd0, prg_mode}, 32'd1);
        chk("full_we_cnt", 32'(we_count - we_base), 32'd151);
        chk("full_last",   32'(last_addr), 32'd150);
        chk("full_bad",    32'(bad_addr), 32'd0);
        read_mem("rd_full0",   32'd0,   32'hC000_5AFF);
        read_mem("rd_full150", 32'd150, 32'hC096_5A69);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 151, giving the number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of word_count and the internal word index.
REQ-003 SHALL have one clock; reset is asynchronous and active-low (ports clk_input and rst_n).
REQ-004 clk_input  input  1  rising-edge clock shared with the instruction memory.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle pulse that begins a program load.
REQ-007 word_count  input  CNT_W  number of words to load, sampled on start.
REQ-008 in_byte  input  8  program byte stream data.
REQ-009 in_valid  input  1  in_byte is valid.
REQ-010 in_ready  output  1  loader accepts in_byte this cycle.
REQ-011 address_pointer  output  32  instruction-memory word address during load.
REQ-012 BUS  inout  32  shared instruction-memory data bus; the loader drives it only while loading.
REQ-013 we  output  1  instruction-memory write enable.
REQ-014 prg_mode  output  1  0 = programming (memory writable, CPU held); 1 = run (memory read by CPU).
REQ-015 busy  output  1  load in progress.
REQ-016 err  output  1  sticky flag: last start had an illegal word_count.

Function
REQ-017 SHALL implement the states IDLE, COLLECT, WRITE and DONE.
REQ-018 IDLE + start with 1 <= word_count <= MEM_DEPTH: latch word_count, clear the index, byte counter and err, then go to COLLECT.
REQ-019 IDLE + start with word_count == 0: go to DONE with err = 0.
REQ-020 IDLE + start with word_count > MEM_DEPTH: set err = 1 and stay in IDLE.
REQ-021 Only in COLLECT SHALL in_ready = 1; a byte transfers on a clock edge where in_valid && in_ready.
REQ-022 Bytes SHALL assemble little-endian:
  - 1st byte -> wdata[7:0]
  - 2nd byte -> wdata[15:8]
  - 3rd byte -> wdata[23:16]
  - 4th byte -> wdata[31:24]
REQ-023 On acceptance of the 4th byte the loader SHALL go to WRITE on the next edge; in_ready = 0 during WRITE.
REQ-024 WRITE SHALL last exactly one cycle, with:
  - we = 1
  - address_pointer = current index, zero-extended to 32 bits
  - BUS = wdata
  - prg_mode = 0
REQ-025 After WRITE the index SHALL increment. If the new index == latched count, go to DONE; otherwise go to COLLECT with the byte counter at 0.
REQ-026 BUS SHALL be driven only in WRITE; it SHALL be high-impedance in every other state.
REQ-027 we SHALL be 1 only in WRITE.
REQ-028 prg_mode SHALL be 0 in IDLE, COLLECT and WRITE, and 1 in DONE.
REQ-029 busy SHALL be 1 in COLLECT and WRITE.
REQ-030 In DONE, address_pointer SHALL hold 0; the top level muxes the CPU PC onto the memory address when prg_mode = 1.
REQ-031 DONE + start SHALL start a new load using the same rules as IDLE (REQ-018 to REQ-020); prg_mode drops to 0 on the next edge unless the count is illegal.
REQ-032 start while busy SHALL be ignored.
REQ-033 Gaps in in_valid SHALL stall assembly without losing partial bytes.
REQ-034 Full-depth load (word_count == MEM_DEPTH) SHALL write the last word at address MEM_DEPTH-1 and never at address MEM_DEPTH.

Reset
REQ-035 rst_n low SHALL immediately force:
  - state = IDLE
  - prg_mode = 0, we = 0, in_ready = 0, busy = 0, err = 0
  - address_pointer = 0
  - BUS = high-impedance
  - partial word discarded
REQ-036 Reset asserted mid-load SHALL abort the load; memory contents already written are unchanged.

Verification
REQ-037 Two-word load: start with word_count = 2, bytes 78 56 34 12 EF BE AD DE -> we pulses twice (addr 0, BUS = 0x12345678; addr 1, BUS = 0xDEADBEEF); prg_mode = 1 one cycle after the second write; the memory then reads these words back.
REQ-038 Stalled stream: in_valid low for 5 cycles between byte 2 and byte 3 -> word assembled correctly; exactly one we pulse per 4 bytes.
REQ-039 Illegal counts:
  - word_count = 152 -> err = 1, state stays IDLE, no we pulse
  - word_count = 0 -> DONE next cycle, prg_mode = 1, no we pulse
REQ-040 Full depth: word_count = 151 -> last write at address 150; 151 we pulses in total; prg_mode = 1 afterwards.
REQ-041 Reset mid-load: rst_n pulsed low after 6 bytes of a 3-word load -> outputs at reset values asynchronously; a new start then loads from address 0.
REQ-042 Reload from DONE: start with word_count = 1 -> prg_mode = 0 next cycle, one write at address 0, prg_mode = 1 again; start pulses while busy have no effect.
